data_mem_responder: RTL and testbench

- Memory-side responder serving the load/store requests issued by the single-cycle ARM datapath: byte address from the ALU result, store data from the register file, 8-bit read data back.
- Wraps a byte-wide synchronous RAM behind a request/ready handshake with a programmable number of wait states, so the core can later be stalled on slow memory.
- Sits between the datapath/control stall logic and the on-chip data RAM.

---
 rtl/data_mem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-wide synchronous data RAM behind a request/ready
// handshake with WAIT_STATES programmable wait cycles.
//
// Handshake: the requester raises mem_req with mem_we/addr/wdata and keeps
// it high until it sees ready. The access is taken on the first rising edge
// in IDLE with mem_req=1. ready (and err when out of range) pulse for exactly
// one cycle. mem_req held high in that cycle starts the next access on the
// following IDLE edge.
//
// Optional feature: define MEMMAP_LED_EN to add a memory-mapped 8-bit LED
// register at byte address 32'hFFFF_FF00 (port leds).
module data_mem_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        err
`ifdef MEMMAP_LED_EN
    ,
    output logic [7:0]  leds
`endif
);

    // Reject unsupported configurations at elaboration time
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("data_mem_responder: WAIT_STATES must be within 0..15");
    end
    if (ADDR_BITS < 1 || ADDR_BITS > 31) begin : g_bad_addr_bits
        $error("data_mem_responder: ADDR_BITS must be within 1..31");
    end

    localparam int          DEPTH     = 2 ** ADDR_BITS;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [31:0] LED_ADDR  = 32'hFFFF_FF00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  ram_q [DEPTH];

    // Access being completed on this edge: straight from the inputs when the
    // request is accepted and answered on the same edge (no wait states),
    // otherwise from the registers latched at acceptance.
    logic [31:0]          acc_addr;
    logic                 acc_we;
    logic [7:0]           acc_wdata;
    logic                 enter_resp;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] acc_idx;

    // Only the low byte of the store data is ever written
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata[31:8];

    function automatic logic addr_in_ram(input logic [31:0] a);
        return (a >> ADDR_BITS) == 32'd0;
    endfunction

    function automatic logic addr_is_led(input logic [31:0] a);
`ifdef MEMMAP_LED_EN
        return a == LED_ADDR;
`else
        return 1'b0 & (a == LED_ADDR);
`endif
    endfunction

`ifdef MEMMAP_LED_EN
    logic [7:0] leds_q, leds_d;
`endif

    // State register plus latched request fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one cycle of RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    addr_d  = addr;
                    we_d    = mem_we;
                    wdata_d = wdata[7:0];
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Select the access that commits on entry into RESP and its read data
    always_comb begin
        acc_addr   = (state_q == S_IDLE) ? addr        : addr_q;
        acc_we     = (state_q == S_IDLE) ? mem_we      : we_q;
        acc_wdata  = (state_q == S_IDLE) ? wdata[7:0]  : wdata_q;
        acc_idx    = acc_addr[ADDR_BITS-1:0];
        enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
        // rst gate keeps a store from landing while reset is held
        ram_we     = enter_resp && acc_we && addr_in_ram(acc_addr) && rst;
        rdata_d    = rdata_q;
        if (enter_resp && !acc_we) begin
            if (addr_in_ram(acc_addr)) begin
                rdata_d = ram_q[acc_idx];
`ifdef MEMMAP_LED_EN
            end else if (addr_is_led(acc_addr)) begin
                rdata_d = leds_q;
`endif
            end else begin
                rdata_d = 8'h00;
            end
        end
    end

    // RAM array: not reset, written only when a store commits
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[acc_idx] <= acc_wdata;
        end
    end

`ifdef MEMMAP_LED_EN
    // LED register update from a store to the mapped address
    always_comb begin
        leds_d = leds_q;
        if (enter_resp && acc_we && addr_is_led(acc_addr)) begin
            leds_d = acc_wdata;
        end
    end

    // LED register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds_q <= 8'h00;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign leds = leds_q;
`endif

    // Outputs: ready/err are decoded from the RESP state and the latched address
    always_comb begin
        ready = (state_q == S_RESP);
        err   = (state_q == S_RESP) && !addr_in_ram(addr_q) && !addr_is_led(addr_q);
        rdata = rdata_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_STATES 0, 1, 3) with
// ADDR_BITS=10, each driven by its own requester and compared against an
// array-based memory model. Define MEMMAP_LED_EN to also cover the LED port.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [7:0]  rdata [3];
    logic        ready [3];
    logic        err   [3];
`ifdef MEMMAP_LED_EN
    logic [7:0]  leds  [3];
`endif

    int          ws [3] = '{0, 1, 3};
    logic [7:0]  mem_m   [3][1024];
    logic [7:0]  last_rd [3];
    logic [7:0]  leds_m  [3];
    int          checks   = 0;
    int          failures = 0;

    // ------------------------------------------------------------ clock/reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ DUTs
    data_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_req(req[0]), .mem_we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0])
`ifdef MEMMAP_LED_EN
        , .leds(leds[0])
`endif
    );
    data_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .mem_req(req[1]), .mem_we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1])
`ifdef MEMMAP_LED_EN
        , .leds(leds[1])
`endif
    );
    data_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .mem_req(req[2]), .mem_we(we[2]), .addr(addr[2]),
        .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]), .err(err[2])
`ifdef MEMMAP_LED_EN
        , .leds(leds[2])
`endif
    );

    // ------------------------------------------------------------ driver
    // Called right after a falling edge. Returns on the falling edge where
    // ready is seen; after_resp means the DUT is still in its response cycle,
    // so acceptance happens one edge later.
    task automatic do_access(input int d, input bit st, input logic [31:0] a,
                             input logic [7:0] wd, input bit hold, input bit after_resp);
        int         n;
        int         exp_n;
        bit         led;
        bit         oor;
        logic [7:0] exp_rd;
        led = 1'b0;
`ifdef MEMMAP_LED_EN
        led = (a == 32'hFFFF_FF00);
`endif
        oor      = (a[31:10] != 22'd0) && !led;
        req[d]   = 1'b1;
        we[d]    = st;
        addr[d]  = a;
        wdata[d] = {24'($urandom()), wd};
        exp_n    = ws[d] + 1 + (after_resp ? 1 : 0);
        n        = 0;
        do begin
            @(negedge clk);
            n++;
            // inputs are don't-care while the access waits
            if (ready[d] !== 1'b1 && !after_resp && n <= ws[d]) begin
                we[d]    = 1'($urandom_range(0, 1));
                addr[d]  = $urandom();
                wdata[d] = $urandom();
            end
        end while (ready[d] !== 1'b1 && n < 40);

        checks++;
        if (ready[d] !== 1'b1 || n != exp_n) begin
            failures++;
            $display("FAIL latency dut%0d addr=%h ready=%b cycles=%0d expected=%0d",
                     d, a, ready[d], n, exp_n);
        end

        checks++;
        if (err[d] !== oor) begin
            failures++;
            $display("FAIL err dut%0d addr=%h got=%b expected=%b", d, a, err[d], oor);
        end

        if (st)            exp_rd = last_rd[d];
        else if (oor)      exp_rd = 8'h00;
        else if (led)      exp_rd = leds_m[d];
        else               exp_rd = mem_m[d][a[9:0]];
        checks++;
        if (rdata[d] !== exp_rd) begin
            failures++;
            $display("FAIL rdata dut%0d %s addr=%h got=%h expected=%h",
                     d, st ? "store" : "load", a, rdata[d], exp_rd);
        end

        if (!st) last_rd[d] = exp_rd;
        if (st && !oor) begin
            if (led) leds_m[d] = wd;
            else     mem_m[d][a[9:0]] = wd;
        end
`ifdef MEMMAP_LED_EN
        checks++;
        if (leds[d] !== leds_m[d]) begin
            failures++;
            $display("FAIL leds dut%0d got=%h expected=%h", d, leds[d], leds_m[d]);
        end
`endif
        if (!hold) req[d] = 1'b0;
    endtask

    function automatic logic [31:0] pool_addr(input int i);
        if (i < 32)       return 32'(i);
        else if (i == 32) return 32'd512;
        else              return 32'd1023;
    endfunction

    task automatic preload_dut(input int d);
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            do_access(d, 1'b1, pool_addr(i), 8'($urandom()), 1'b0, 1'b0);
        end
    endtask

    task automatic rand_dut(input int d);
        bit          prev_hold;
        bit          hold;
        logic [31:0] a;
        prev_hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!prev_hold) repeat ($urandom_range(1, 3)) @(negedge clk);
            if ($urandom_range(0, 9) < 8) a = pool_addr(int'($urandom_range(0, 33)));
            else a = {22'($urandom_range(1, 4194303)), 10'($urandom())};
            hold = (i != 39) && ($urandom_range(0, 1) == 1);
            do_access(d, 1'($urandom_range(0, 1)), a, 8'($urandom()), hold, prev_hold);
            prev_hold = hold;
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            req[d]   = 1'b1;
            we[d]    = 1'b1;
            addr[d]  = 32'h5;
            wdata[d] = 32'hC3;
            last_rd[d] = 8'h00;
            leds_m[d]  = 8'h00;
        end
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ready[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 8'h00) begin
                failures++;
                $display("FAIL reset_outputs dut%0d ready=%b err=%b rdata=%h expected 0/0/00",
                         d, ready[d], err[d], rdata[d]);
            end
        end
        rst = 1'b1;
        fork
            do_access(0, 1'b1, 32'h5, 8'hC3, 1'b0, 1'b0);
            do_access(1, 1'b1, 32'h5, 8'hC3, 1'b0, 1'b0);
            do_access(2, 1'b1, 32'h5, 8'hC3, 1'b0, 1'b0);
        join
    endtask

    task automatic test_preload();
        fork
            preload_dut(0);
            preload_dut(1);
            preload_dut(2);
        join
    endtask

    task automatic test_store_load_w1();
        @(negedge clk);
        do_access(1, 1'b1, 32'h10, 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        do_access(1, 1'b0, 32'h10, 8'h00, 1'b0, 1'b0);
        checks++;
        if (rdata[1] !== 8'hA5) begin
            failures++;
            $display("FAIL w1_load_value got=%h expected=a5", rdata[1]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        do_access(0, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        do_access(0, 1'b0, 32'h1, 8'h00, 1'b1, 1'b1);
        do_access(0, 1'b1, 32'h2, 8'h6C, 1'b1, 1'b1);
        do_access(0, 1'b0, 32'h2, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        do_access(1, 1'b1, 32'h7, 8'h3E, 1'b1, 1'b0);
        do_access(1, 1'b0, 32'h7, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        do_access(1, 1'b1, 32'h400, 8'h33, 1'b0, 1'b0);
        @(negedge clk);
        do_access(1, 1'b0, 32'h000, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        do_access(1, 1'b0, 32'h8000_0010, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        do_access(2, 1'b1, 32'hFFFF_FF00 ^ 32'h1, 8'h44, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_access();
        bit seen;
        @(negedge clk);
        do_access(2, 1'b1, 32'h20, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        req[2]   = 1'b1;
        we[2]    = 1'b1;
        addr[2]  = 32'h20;
        wdata[2] = 32'h5A;
        @(negedge clk);
        req[2] = 1'b0;
        rst    = 1'b0;
        seen   = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ready[2] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_no_ready ready pulsed=1 expected=0");
        end
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            last_rd[d] = 8'h00;
            leds_m[d]  = 8'h00;
            checks++;
            if (rdata[d] !== 8'h00) begin
                failures++;
                $display("FAIL rdata_after_reset dut%0d got=%h expected=00", d, rdata[d]);
            end
        end
        @(negedge clk);
        do_access(2, 1'b0, 32'h20, 8'h00, 1'b0, 1'b0);
        checks++;
        if (rdata[2] !== 8'h11) begin
            failures++;
            $display("FAIL abort_store_dropped got=%h expected=11", rdata[2]);
        end
    endtask

    task automatic test_random();
        fork
            rand_dut(0);
            rand_dut(1);
            rand_dut(2);
        join
    endtask

`ifdef MEMMAP_LED_EN
    task automatic test_leds();
        @(negedge clk);
        do_access(1, 1'b1, 32'hFFFF_FF00, 8'h81, 1'b0, 1'b0);
        @(negedge clk);
        do_access(1, 1'b0, 32'hFFFF_FF00, 8'h00, 1'b0, 1'b0);
        checks++;
        if (leds[1] !== 8'h81 || rdata[1] !== 8'h81) begin
            failures++;
            $display("FAIL led_map leds=%h rdata=%h expected=81/81", leds[1], rdata[1]);
        end
    endtask
`endif

    // ------------------------------------------------------------ sequence
    initial begin
        test_reset();
        test_preload();
        test_store_load_w1();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_access();
        test_random();
`ifdef MEMMAP_LED_EN
        test_leds();
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
